// File: rtl/pio_pkg.sv
// Register map and edge-select encodings shared by the button input PIO and the LED output PIO.
package pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_RSVD     = 2'd1,
        ADDR_IRQ_MASK = 2'd2,
        ADDR_EDGE_CAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Bits whose level change matches the selected edge type, given current and previous levels.
    function automatic logic [31:0] edge_hits(input logic [31:0] curr,
                                              input logic [31:0] prev,
                                              input int          edge_type);
        case (edge_type)
            EDGE_RISING:  return curr & ~prev;
            EDGE_FALLING: return ~curr & prev;
            default:      return curr ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stability counter that gates the accepted level.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);

    logic sync1;
    logic sync2;

    // NOTE: every clocked assignment uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                level <= 1'b0;
            end else begin
                level <= sync2;
            end
        end
    end else begin : g_count
        localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] count;

        // The count only advances while the synchronized input disagrees; it tops out at LAST.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count <= '0;
                level <= 1'b0;
            end else if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                level <= sync2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_pio_in.sv
// Avalon-MM input PIO: per-bit debounce, edge capture with write-1-to-clear, maskable level irq.
module button_pio_in
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clear;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .din  (in_port[i]),
            .level(debounced[i])
        );
    end

    assign wr_en     = chipselect && !write_n;
    assign edge_hit  = WIDTH'(edge_hits(32'(debounced), 32'(deb_prev), EDGE_TYPE));
    assign cap_clear = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge ORs in after the clear so a coincident set always survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            deb_prev <= debounced;
            edge_cap <= (edge_cap & ~cap_clear) | edge_hit;
            if (wr_en && address == ADDR_IRQ_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // NOTE: readdata gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        readdata = '0;
        case (pio_addr_e'(address))
            ADDR_DATA:     readdata = 32'(debounced);
            ADDR_IRQ_MASK: readdata = 32'(irq_mask);
            ADDR_EDGE_CAP: readdata = 32'(edge_cap);
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edge_cap & irq_mask);

    // Write-data bits above WIDTH are deliberately dropped.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

endmodule

// File: tb/tb_button_pio_in.sv
// Directed and randomized checks of button_pio_in (WIDTH=8, DEBOUNCE_CYCLES=4, rising edges).
module tb_button_pio_in;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] hist[$];
    logic [7:0] m_deb, m_deb_prev, m_mask, m_cap;

    button_pio_in #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(DEB),
        .EDGE_TYPE(0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] past_in(input int back);
        int idx;
        idx = hist.size() - 1 - back;
        return (idx >= 0) ? hist[idx] : 8'h00;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_deb};
            2'd2:    return {24'h0, m_mask};
            2'd3:    return {24'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        hist.delete();
        m_deb = 8'h00; m_deb_prev = 8'h00; m_mask = 8'h00; m_cap = 8'h00;
    endtask

    // One clock: sample inputs, wait for the edge, advance the model, return at the falling edge.
    // A level is accepted once the twice-synchronized input has disagreed with it for DEB edges.
    task automatic cycle();
        logic [7:0] s_in, s_wd, clr, flip;
        logic [1:0] s_addr;
        logic       wr;
        s_in   = in_port;
        wr     = chipselect && !write_n;
        s_addr = address;
        s_wd   = writedata[7:0];
        @(posedge clk);
        if (!reset) begin
            clr   = (wr && s_addr == 2'd3) ? s_wd : 8'h00;
            m_cap = (m_cap & ~clr) | (m_deb & ~m_deb_prev);
            if (wr && s_addr == 2'd2) m_mask = s_wd;
            flip = 8'hFF;
            for (int k = 0; k < DEB; k++) flip &= past_in(1 + k) ^ m_deb;
            m_deb_prev = m_deb;
            m_deb      = m_deb ^ flip;
            hist.push_back(s_in);
            if (hist.size() > 32) void'(hist.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; in_port = 8'h00; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        model_clear();
        repeat (3) cycle();
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), v);
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL reset_read addr%0d: got %h expected 00000000", a, v);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        repeat (2) cycle();
        peek(2'd0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL post_reset_data: got %h expected 0", v); end
    endtask

    task automatic test_step();
        logic [31:0] v;
        in_port[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            peek(2'd0, v);
            checks++;
            if (v !== ((i == 6) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL step_data edge%0d: got %h expected %h", i, v, (i == 6) ? 1 : 0);
            end
            peek(2'd3, v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL step_cap_early edge%0d: got %h expected 0", i, v); end
        end
        cycle();
        peek(2'd3, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL step_cap: got %h expected 00000001", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL step_irq_masked: got %b expected 0", irq); end
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        logic [6:0]  pat;
        pat = 7'b0110111;
        for (int i = 0; i < 17; i++) begin
            in_port[1] = (i < 7) ? pat[i] : 1'b0;
            cycle();
            peek(2'd0, v);
            checks++;
            if (v[1] !== 1'b0) begin errors++; $display("FAIL bounce_data cycle%0d: got %b expected 0", i, v[1]); end
            peek(2'd3, v);
            checks++;
            if (v[1] !== 1'b0) begin errors++; $display("FAIL bounce_cap cycle%0d: got %b expected 0", i, v[1]); end
        end
    endtask

    task automatic test_mask_clear();
        logic [31:0] v;
        in_port[0] = 1'b0;
        repeat (8) cycle();
        peek(2'd0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL fall_data: got %h expected 0", v); end
        peek(2'd3, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL fall_not_captured: got %h expected 00000001", v); end
        bus_write(2'd3, 32'hFF);
        peek(2'd3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL clear_all: got %h expected 0", v); end
        bus_write(2'd2, 32'hFFFF_FF01);
        peek(2'd2, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL mask_readback: got %h expected 00000001", v); end
        bus_write(2'd1, 32'hFFFF_FFFF);
        peek(2'd1, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 0", v); end
        in_port[0] = 1'b1;
        repeat (6) cycle();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
        cycle();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
        bus_write(2'd3, 32'h2);
        peek(2'd3, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL clear_other_bit: got %h expected 00000001", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_kept: got %b expected 1", irq); end
        bus_write(2'd3, 32'h1);
        peek(2'd3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL clear_bit0: got %h expected 0", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    endtask

    task automatic test_set_clear_collision();
        logic [31:0] v;
        in_port[0] = 1'b0;
        repeat (8) cycle();
        in_port[0] = 1'b1;
        repeat (6) cycle();
        peek(2'd0, v);
        checks++;
        if (v[0] !== 1'b1) begin errors++; $display("FAIL collide_data: got %b expected 1", v[0]); end
        peek(2'd3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL collide_cap_before: got %h expected 0", v); end
        bus_write(2'd3, 32'h1);
        peek(2'd3, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL collide_set_wins: got %h expected 00000001", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", irq); end
        cycle();
        peek(2'd3, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL collide_hold: got %h expected 00000001", v); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        reset   = 1'b1;
        in_port = 8'h00;
        model_clear();
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), v);
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL async_reset addr%0d: got %h expected 0", a, v);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
        #1 reset = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] v;
        in_port[2] = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        model_clear();
        repeat (2) cycle();
        peek(2'd0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_data: got %h expected 0", v); end
        peek(2'd3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_cap: got %h expected 0", v); end
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            peek(2'd0, v);
            checks++;
            if (v !== ((i >= 6) ? 32'h4 : 32'h0)) begin
                errors++; $display("FAIL release_data edge%0d: got %h expected %h", i, v, (i >= 6) ? 4 : 0);
            end
            peek(2'd3, v);
            checks++;
            if (v !== ((i >= 7) ? 32'h4 : 32'h0)) begin
                errors++; $display("FAIL release_cap edge%0d: got %h expected %h", i, v, (i >= 7) ? 4 : 0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, exp;
        int          hold;
        hold = 0;
        for (int i = 0; i < 500; i++) begin
            for (int a = 0; a < 4; a++) begin
                peek(2'(a), v);
                exp = m_read(2'(a));
                checks++;
                if (v !== exp) begin
                    errors++; $display("FAIL rand_read cycle%0d addr%0d: got %h expected %h", i, a, v, exp);
                end
            end
            checks++;
            if (irq !== |(m_cap & m_mask)) begin
                errors++; $display("FAIL rand_irq cycle%0d: got %b expected %b", i, irq, |(m_cap & m_mask));
            end
            if (hold == 0) begin
                in_port = 8'($urandom);
                hold    = $urandom_range(1, 10);
            end
            hold--;
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            cycle();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_mask_clear();
        test_set_clear_collision();
        test_async_reset();
        test_reset_mid_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
